// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Bundles the fetch-control inputs, the instruction handshake
//               and the instruction-memory bus of the fetch stage. Buses use
//               [0:N-1] ordering with bit 0 as the MSB.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32
);
    // Fetch control
    logic                    fetch_en;
    logic                    redirect;
    logic [0:ADDRESS_SIZE-1] redirect_pc;

    // Instruction handshake towards decode
    logic                    insn_ready;
    logic                    insn_valid;
    logic [0:DATA_SIZE-1]    insn_out;
    logic [0:ADDRESS_SIZE-1] pc_out;

    // Instruction memory bus
    logic [0:ADDRESS_SIZE-1] mem_addr;
    logic                    mem_en;
    logic                    mem_wren;
    logic [0:1]              mem_acc_size;
    logic [0:DATA_SIZE-1]    mem_d_out;
    logic                    mem_busy;

    // Fetch unit side
    modport master (
        input  fetch_en, redirect, redirect_pc, insn_ready, mem_d_out, mem_busy,
        output insn_valid, insn_out, pc_out, mem_addr, mem_en, mem_wren, mem_acc_size
    );

    // Environment side (control, decode and memory)
    modport slave (
        output fetch_en, redirect, redirect_pc, insn_ready, mem_d_out, mem_busy,
        input  insn_valid, insn_out, pc_out, mem_addr, mem_en, mem_wren, mem_acc_size
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Issues word reads to instruction
//               memory, captures the returned word at the end of the request
//               cycle and presents it on a valid/ready handshake. Supports a
//               one-cycle redirect pulse that overrides any in-flight read.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int                      ADDRESS_SIZE = 32,
    parameter int                      DATA_SIZE    = 32,
    parameter logic [0:ADDRESS_SIZE-1] START_PC     = 32'h80020000
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    instr_fetch_if.master bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    localparam logic [0:ADDRESS_SIZE-1] c_PC_STEP = ADDRESS_SIZE'(4);

    // Registered state
    state_t                  r_state;
    logic [0:ADDRESS_SIZE-1] r_pc;
    logic [0:ADDRESS_SIZE-1] r_mem_addr;
    logic                    r_mem_en;
    logic                    r_insn_valid;
    logic [0:DATA_SIZE-1]    r_insn_out;
    logic [0:ADDRESS_SIZE-1] r_pc_out;

    // Next-state values
    state_t                  w_state_nx;
    logic [0:ADDRESS_SIZE-1] w_pc_nx;
    logic [0:ADDRESS_SIZE-1] w_mem_addr_nx;
    logic                    w_mem_en_nx;
    logic                    w_insn_valid_nx;
    logic [0:DATA_SIZE-1]    w_insn_out_nx;
    logic [0:ADDRESS_SIZE-1] w_pc_out_nx;

    // Helpers
    logic                    w_slot_free;
    logic                    w_capture;
    logic [0:ADDRESS_SIZE-1] w_next_addr;
    logic [0:ADDRESS_SIZE-1] w_redirect_tgt;

    // Output slot can take a new word when empty or being drained this cycle.
    assign w_slot_free    = !r_insn_valid || bus.insn_ready;
    assign w_capture      = (r_state == FETCH) && !bus.mem_busy && w_slot_free;
    // Wraps naturally modulo 2^ADDRESS_SIZE.
    assign w_next_addr    = r_mem_addr + c_PC_STEP;
    // Targets are word aligned: the two least significant bits are dropped.
    assign w_redirect_tgt = {bus.redirect_pc[0:ADDRESS_SIZE-3], 2'b00};

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pc         <= START_PC;
            r_mem_addr   <= START_PC;
            r_mem_en     <= 1'b0;
            r_insn_valid <= 1'b0;
            r_insn_out   <= '0;
            r_pc_out     <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_pc         <= w_pc_nx;
            r_mem_addr   <= w_mem_addr_nx;
            r_mem_en     <= w_mem_en_nx;
            r_insn_valid <= w_insn_valid_nx;
            r_insn_out   <= w_insn_out_nx;
            r_pc_out     <= w_pc_out_nx;
        end
    end

    // Next-state and datapath decisions; redirect overrides everything else.
    always_comb begin
        w_state_nx      = r_state;
        w_pc_nx         = r_pc;
        w_mem_addr_nx   = r_mem_addr;
        w_mem_en_nx     = r_mem_en;
        w_insn_valid_nx = r_insn_valid;
        w_insn_out_nx   = r_insn_out;
        w_pc_out_nx     = r_pc_out;

        // A word handed over this cycle leaves the slot unless refilled below.
        if (r_insn_valid && bus.insn_ready) begin
            w_insn_valid_nx = 1'b0;
        end

        if (bus.redirect) begin
            // Drop any in-flight read and any word still waiting in the slot.
            w_pc_nx         = w_redirect_tgt;
            w_mem_addr_nx   = w_redirect_tgt;
            w_insn_valid_nx = 1'b0;
            w_state_nx      = bus.fetch_en ? FETCH : IDLE;
            w_mem_en_nx     = bus.fetch_en;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.fetch_en) begin
                        w_state_nx    = FETCH;
                        w_mem_addr_nx = r_pc;
                        w_mem_en_nx   = 1'b1;
                    end
                end
                FETCH: begin
                    // Without a capture the same address is simply re-read.
                    if (w_capture) begin
                        w_insn_out_nx   = bus.mem_d_out;
                        w_pc_out_nx     = r_mem_addr;
                        w_insn_valid_nx = 1'b1;
                        w_pc_nx         = w_next_addr;
                        if (bus.fetch_en) begin
                            w_mem_addr_nx = w_next_addr;
                        end else begin
                            w_state_nx  = IDLE;
                            w_mem_en_nx = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_nx  = IDLE;
                    w_mem_en_nx = 1'b0;
                end
            endcase
        end
    end

    assign bus.insn_valid   = r_insn_valid;
    assign bus.insn_out     = r_insn_out;
    assign bus.pc_out       = r_pc_out;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_en       = r_mem_en;
    assign bus.mem_wren     = 1'b0;
    assign bus.mem_acc_size = 2'b10;

endmodule
`default_nettype wire
